train_state: RTL and testbench



---
 rtl/train_state.sv | 122 ++++++++++++
 tb/tb_train_state.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/train_state.sv
// train_state: Moore controller arbitrating two trains over one shared track section.
// Four level sensors in, three switch positions and two 2-bit motor codes out.
// Optional build macro TRAINSTATE_SENSOR_SYNC_EN adds a 2-flop sensor synchronizer
// ahead of the next-state logic; without it the sensors feed next-state directly.
//
// state  | meaning
// -------+------------------------------------------------
// ABOUT  | both trains on their outer loops
// AIN    | A in the common section
// BIN    | B in the common section
// ASTOP  | B in the common section, A held at the entry
// BSTOP  | A in the common section, B held at the entry
module train_state (
    input  logic       Clock,
    input  logic       RESET,
    input  logic [4:1] SR,
    output logic [3:1] SW,
    output logic [1:0] DA,
    output logic [1:0] DB
);

    typedef enum logic [2:0] {
        S_ABOUT = 3'b000,
        S_AIN   = 3'b001,
        S_BIN   = 3'b010,
        S_ASTOP = 3'b011,
        S_BSTOP = 3'b100
    } state_t;

    localparam logic [1:0] MOTOR_FWD  = 2'b01;
    localparam logic [1:0] MOTOR_STOP = 2'b00;

    state_t     state_q;
    state_t     state_d;
    logic [4:1] sr_eff;

`ifdef TRAINSTATE_SENSOR_SYNC_EN
    logic [4:1] sr_meta_q;
    logic [4:1] sr_meta_d;
    logic [4:1] sr_sync_q;
    logic [4:1] sr_sync_d;

    // Synchronizer next values: each stage copies the one before it.
    always_comb begin
        sr_meta_d = SR;
        sr_sync_d = sr_meta_q;
    end

    // Two-stage sensor synchronizer, cleared on reset.
    always_ff @(posedge Clock or posedge RESET) begin
        if (RESET) begin
            sr_meta_q <= '0;
            sr_sync_q <= '0;
        end else begin
            sr_meta_q <= sr_meta_d;
            sr_sync_q <= sr_sync_d;
        end
    end

    assign sr_eff = sr_sync_q;
`else
    assign sr_eff = SR;
`endif

    // State register; reset forces ABOUT without waiting for a clock.
    always_ff @(posedge Clock or posedge RESET) begin
        if (RESET) begin
            state_q <= S_ABOUT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: exits outrank entries, A outranks B on a tie at ABOUT.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_ABOUT: begin
                if (sr_eff[1])      state_d = S_AIN;
                else if (sr_eff[2]) state_d = S_BIN;
            end
            S_AIN: begin
                if (sr_eff[4])      state_d = S_ABOUT;
                else if (sr_eff[2]) state_d = S_BSTOP;
            end
            S_BIN: begin
                if (sr_eff[3])      state_d = S_ABOUT;
                else if (sr_eff[1]) state_d = S_ASTOP;
            end
            S_ASTOP: begin
                if (sr_eff[3])      state_d = S_AIN;
            end
            S_BSTOP: begin
                if (sr_eff[4])      state_d = S_BIN;
            end
            default: state_d = S_ABOUT;
        endcase
    end

    // Output decode from the state register only; unused codes look like ABOUT.
    always_comb begin
        SW = 3'b000;
        DA = MOTOR_FWD;
        DB = MOTOR_FWD;
        case (state_q)
            S_BIN: begin
                SW = 3'b011;
            end
            S_ASTOP: begin
                SW = 3'b011;
                DA = MOTOR_STOP;
            end
            S_BSTOP: begin
                DB = MOTOR_STOP;
            end
            default: begin
                SW = 3'b000;
            end
        endcase
    end

endmodule

// File: tb/tb_train_state.sv
// tb_train_state: randomized and directed bench for train_state (default build).
// The reference tracks which train occupies the common section and which one,
// if any, is being held at the entry; outputs follow from those two facts.
module tb_train_state;

    logic       Clock = 1'b0;
    logic       RESET = 1'b0;
    logic [4:1] SR    = 4'b0000;
    logic [3:1] SW;
    logic [1:0] DA;
    logic [1:0] DB;

    int checks  = 0;
    int errors  = 0;
    bit started = 1'b0;

    // occupant: 0 = nobody, 1 = train A, 2 = train B
    // held:     0 = nobody, 1 = train A waiting, 2 = train B waiting
    int occupant = 0;
    int held     = 0;

    train_state dut (
        .Clock (Clock),
        .RESET (RESET),
        .SR    (SR),
        .SW    (SW),
        .DA    (DA),
        .DB    (DB)
    );

    always #5 Clock = ~Clock;

    task automatic model_step(input logic [4:1] s);
        if (occupant == 0) begin
            if (s[1])      occupant = 1;
            else if (s[2]) occupant = 2;
        end else if (occupant == 1 && held == 0) begin
            if (s[4])      occupant = 0;
            else if (s[2]) held = 2;
        end else if (occupant == 2 && held == 0) begin
            if (s[3])      occupant = 0;
            else if (s[1]) held = 1;
        end else if (occupant == 2 && held == 1) begin
            if (s[3]) begin occupant = 1; held = 0; end
        end else if (occupant == 1 && held == 2) begin
            if (s[4]) begin occupant = 2; held = 0; end
        end
    endtask

    function automatic logic [2:0] exp_sw();
        return (occupant == 2) ? 3'b011 : 3'b000;
    endfunction
    function automatic logic [1:0] exp_da();
        return (held == 1) ? 2'b00 : 2'b01;
    endfunction
    function automatic logic [1:0] exp_db();
        return (held == 2) ? 2'b00 : 2'b01;
    endfunction

    always @(posedge Clock or posedge RESET) begin
        if (RESET) begin
            occupant = 0;
            held     = 0;
        end else begin
            model_step(SR);
        end
    end

    task automatic check(input string name, input logic [2:0] sw_a, input logic [1:0] da_a,
                         input logic [1:0] db_a, input logic [2:0] sw_e,
                         input logic [1:0] da_e, input logic [1:0] db_e);
        checks++;
        if (sw_a !== sw_e || da_a !== da_e || db_a !== db_e) begin
            errors++;
            $display("FAIL %s at %0t: got SW=%b DA=%b DB=%b, expected SW=%b DA=%b DB=%b",
                     name, $time, sw_a, da_a, db_a, sw_e, da_e, db_e);
        end
    endtask

    // Per-cycle compare against the model.
    always @(negedge Clock) begin
        if (started) check("cycle", SW, DA, DB, exp_sw(), exp_da(), exp_db());
    end

    // Literal expectation pinned on both the DUT and the model.
    task automatic check_lit(input string name, input logic [2:0] sw_e,
                             input logic [1:0] da_e, input logic [1:0] db_e);
        check(name, SW, DA, DB, sw_e, da_e, db_e);
        check({"model_", name}, exp_sw(), exp_da(), exp_db(), sw_e, da_e, db_e);
    endtask

    task automatic step(input logic [4:1] v, input string name, input logic [2:0] sw_e,
                        input logic [1:0] da_e, input logic [1:0] db_e);
        SR = v;
        @(posedge Clock);
        #1;
        check_lit(name, sw_e, da_e, db_e);
    endtask

    initial begin
        #1;
        RESET = 1'b1;
        SR    = 4'b0001;
        #1;
        check_lit("reset_immediate", 3'b000, 2'b01, 2'b01);
        repeat (2) @(posedge Clock);
        #1;
        check_lit("reset_held", 3'b000, 2'b01, 2'b01);
        @(negedge Clock);
        RESET   = 1'b0;
        SR      = 4'b0000;
        started = 1'b1;

        step(4'b0100, "about_hold",      3'b000, 2'b01, 2'b01);
        step(4'b0010, "bin",             3'b011, 2'b01, 2'b01);
        step(4'b1000, "bin_hold",        3'b011, 2'b01, 2'b01);
        step(4'b0001, "astop",           3'b011, 2'b00, 2'b01);
        step(4'b0100, "ain_from_astop",  3'b000, 2'b01, 2'b01);
        step(4'b1010, "ain_exit_prio",   3'b000, 2'b01, 2'b01);
        step(4'b0101, "about_a_wins",    3'b000, 2'b01, 2'b01);
        step(4'b1010, "ain_exit",        3'b000, 2'b01, 2'b01);
        for (int i = 0; i < 2; i++) begin
            step(4'b0001, "loop_ain",    3'b000, 2'b01, 2'b01);
            step(4'b1010, "loop_about",  3'b000, 2'b01, 2'b01);
        end
        step(4'b0001, "ain2",            3'b000, 2'b01, 2'b01);
        step(4'b0010, "bstop",           3'b000, 2'b01, 2'b00);
        step(4'b0000, "bstop_hold",      3'b000, 2'b01, 2'b00);
        step(4'b1000, "bin_from_bstop",  3'b011, 2'b01, 2'b01);
        step(4'b0001, "astop2",          3'b011, 2'b00, 2'b01);

        #2;
        RESET = 1'b1;
        #1;
        check_lit("reset_mid_cycle", 3'b000, 2'b01, 2'b01);
        @(negedge Clock);
        RESET = 1'b0;
        SR    = 4'b0000;
        step(4'b0010, "bin_after_reset", 3'b011, 2'b01, 2'b01);

        for (int i = 0; i < 3000; i++) begin
            SR = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 99) == 0) begin
                RESET = 1'b1;
                #2;
                RESET = 1'b0;
            end
            @(posedge Clock);
            #1;
        end

        @(negedge Clock);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
